clk_div_multi: RTL and testbench

- Parametrised, multi-channel successor to the fixed 70 Hz toggle divider.
- Each of NUM_CH channels generates a square wave with a runtime-programmable period and high time, plus a one-cycle start-of-period tick strobe.
- Config changes are glitch-free: a shadow register holds each update and applies it at the next period boundary.
- Feeds display multiplexing, debounce sampling and LED/beeper timing from the single system clock.

---
 rtl/clk_div_pkg.sv | 29 ++
 rtl/clk_div_chan.sv | 116 +++++++++++
 rtl/clk_div_multi.sv | 64 ++++++
 tb/tb_clk_div_multi.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg
//   Shared constants and the config clamp helper for the multi-channel
//   clock divider (clk_div_multi / clk_div_chan).
package clk_div_pkg;

  localparam int          DFLT_CNT_W  = 32;
  localparam int unsigned DFLT_PERIOD = 1428571;  // 70 Hz at 100 MHz
  localparam int unsigned DFLT_HIGH   = 714285;   // 50% duty

  // Widest counter the clamp helper handles; channels zero-extend into it.
  localparam int CFG_W_MAX = 64;

  typedef struct packed {
    logic [CFG_W_MAX-1:0] period;
    logic [CFG_W_MAX-1:0] high;
  } cfg_t;

  // Period below 2 becomes 2. High time above the period saturates at the
  // period, which keeps the output high for the whole period; a high time
  // of 0 needs no treatment since no count is below 0.
  function automatic cfg_t clamp_cfg(input logic [CFG_W_MAX-1:0] period,
                                     input logic [CFG_W_MAX-1:0] high);
    cfg_t c;
    c.period = (period < CFG_W_MAX'(2)) ? CFG_W_MAX'(2) : period;
    c.high   = (high > c.period) ? c.period : high;
    return c;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan
//   One divider channel: period counter, shadow and active config, and
//   registered clk_out / tick outputs. Config written while the channel is
//   mid-period waits in the shadow until the next period boundary.
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   en                    run enable
//   sync                  restart the period (only while enabled)
//   we                    write strobe for this channel
//   wr_period, wr_high    config values being written
//   clk_out, tick         divided clock and start-of-period strobe
//   pending               a shadowed config is waiting for its boundary
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          CNT_W      = DFLT_CNT_W,
  parameter int unsigned DEF_PERIOD = DFLT_PERIOD,
  parameter int unsigned DEF_HIGH   = DFLT_HIGH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             we,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_high,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_P = CNT_W'((DEF_PERIOD < 2) ? 2 : DEF_PERIOD);
  localparam logic [CNT_W-1:0] RST_H = CNT_W'(DEF_HIGH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] p_act_q, p_act_d, h_act_q, h_act_d;
  logic [CNT_W-1:0] p_sh_q, p_sh_d, h_sh_q, h_sh_d;
  logic             pend_q, pend_d, clk_out_q, clk_out_d, tick_q, tick_d;

  cfg_t wr_c, sh_c;
  logic last, restart, boundary;

  assign wr_c = clamp_cfg(CFG_W_MAX'(wr_period), CFG_W_MAX'(wr_high));
  assign sh_c = clamp_cfg(CFG_W_MAX'(p_sh_q), CFG_W_MAX'(h_sh_q));

  // Wrap decision always uses the period that was active going into the edge.
  assign last     = (cnt_q == p_act_q - ONE);
  assign restart  = sync | last;
  // A disabled channel is permanently at a boundary, so pending config
  // (and any write) lands in active straight away.
  assign boundary = ~en | restart;

  always_comb begin
    cnt_d     = cnt_q;
    p_act_d   = p_act_q;
    h_act_d   = h_act_q;
    p_sh_d    = p_sh_q;
    h_sh_d    = h_sh_q;
    pend_d    = pend_q;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;

    if (boundary) begin
      // A write coinciding with the boundary bypasses the shadow.
      if (we) begin
        p_act_d = CNT_W'(wr_c.period);
        h_act_d = CNT_W'(wr_c.high);
      end else if (pend_q) begin
        p_act_d = CNT_W'(sh_c.period);
        h_act_d = CNT_W'(sh_c.high);
      end
      pend_d = 1'b0;
    end else if (we) begin
      p_sh_d = wr_period;
      h_sh_d = wr_high;
      pend_d = 1'b1;
    end

    if (en) begin
      cnt_d     = restart ? '0 : cnt_q + ONE;
      clk_out_d = (cnt_d < h_act_d);
      tick_d    = restart;
    end else begin
      // Parked on the last count so the first enabled edge wraps to 0.
      cnt_d = p_act_d - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= RST_P - ONE;
      p_act_q   <= RST_P;
      h_act_q   <= RST_H;
      p_sh_q    <= '0;
      h_sh_q    <= '0;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      p_act_q   <= p_act_d;
      h_act_q   <= h_act_d;
      p_sh_q    <= p_sh_d;
      h_sh_q    <= h_sh_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi
//   NUM_CH independent programmable clock dividers sharing one system clock.
//   Decodes the config channel select into per-channel write strobes and
//   fans sync out to every channel.
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   en[NUM_CH]            per-channel run enable
//   sync                  phase-align pulse for all enabled channels
//   cfg_we, cfg_ch        config write strobe and target channel
//   cfg_period, cfg_high  new period / high time in clk cycles
//   clk_out, tick         per-channel divided clock and period strobe
//   cfg_pending           per-channel config-waiting flag
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = DFLT_CNT_W,
  parameter int unsigned DEF_PERIOD = DFLT_PERIOD,
  parameter int unsigned DEF_HIGH   = DFLT_HIGH,
  localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  logic [NUM_CH-1:0] ch_we;

  // Select values with no matching channel simply produce no strobe.
  always_comb begin
    ch_we = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_chan #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en[g]),
      .sync      (sync),
      .we        (ch_we[g]),
      .wr_period (cfg_period),
      .wr_high   (cfg_high),
      .clk_out   (clk_out[g]),
      .tick      (tick[g]),
      .pending   (cfg_pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

  localparam int NCH = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NCH-1:0]  en;
  logic            sync;
  logic            cfg_we;
  logic [1:0]      cfg_ch;
  logic [31:0]     cfg_period;
  logic [31:0]     cfg_high;
  logic [NCH-1:0]  clk_out;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  cfg_pending;

  clk_div_multi #(
    .NUM_CH     (NCH),
    .CNT_W      (32),
    .DEF_PERIOD (6),
    .DEF_HIGH   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sync        (sync),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
    .clk_out     (clk_out),
    .tick        (tick),
    .cfg_pending (cfg_pending)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position within the current period plus active and
  // waiting configs; outputs follow directly from position vs high time.
  longint m_p[NCH], m_h[NCH], m_pos[NCH], m_sp[NCH], m_sh[NCH];
  bit     m_pend[NCH], m_clk[NCH], m_tick[NCH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint eff_period(input longint p);
    return (p < 2) ? 2 : p;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_p[c] = 6; m_h[c] = 3; m_pos[c] = 5;
      m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      m_sp[c] = 0; m_sh[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit     wr;
      bit     new_period;
      wr = (cfg_we === 1'b1) && (int'(cfg_ch) == c);
      new_period = (en[c] === 1'b1) && ((sync === 1'b1) || (m_pos[c] == m_p[c] - 1));
      if (en[c] !== 1'b1 || new_period) begin
        if (wr) begin
          m_p[c] = eff_period(longint'(cfg_period)); m_h[c] = longint'(cfg_high);
        end else if (m_pend[c]) begin
          m_p[c] = eff_period(m_sp[c]); m_h[c] = m_sh[c];
        end
        m_pend[c] = 0;
      end else if (wr) begin
        m_sp[c] = longint'(cfg_period); m_sh[c] = longint'(cfg_high); m_pend[c] = 1;
      end
      if (en[c] === 1'b1) begin
        m_pos[c]  = new_period ? 0 : m_pos[c] + 1;
        m_clk[c]  = (m_pos[c] < m_h[c]);
        m_tick[c] = (m_pos[c] == 0);
      end else begin
        m_pos[c]  = m_p[c] - 1;
        m_clk[c]  = 0;
        m_tick[c] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("%s clk_out[%0d]", tag, c), 64'(clk_out[c]), 64'(m_clk[c]));
      check($sformatf("%s tick[%0d]", tag, c), 64'(tick[c]), 64'(m_tick[c]));
      check($sformatf("%s cfg_pending[%0d]", tag, c), 64'(cfg_pending[c]), 64'(m_pend[c]));
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [31:0] p, input logic [31:0] h,
                           input string tag);
    cfg_we = 1'b1; cfg_ch = ch; cfg_period = p; cfg_high = h;
    cycle(tag);
    cfg_we = 1'b0;
  endtask

  initial begin
    int  waited;
    rst_n = 1'b0; en = '0; sync = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_period = '0; cfg_high = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    cycle("idle");

    // Default 6/3 cadence on channel 0 from its enable edge.
    en[0] = 1'b1;
    for (int j = 0; j < 13; j++) begin
      cycle("dflt");
      check("dflt tick0 cadence", 64'(tick[0]), 64'((j % 6) == 0));
      check("dflt clk0 duty", 64'(clk_out[0]), 64'((j % 6) < 3));
    end

    // Mid-period write waits for the wrap.
    en[1] = 1'b1;
    repeat (3) cycle("ch1 run");
    write_cfg(2'd1, 32'd5, 32'd2, "ch1 wr");
    check("ch1 pending after write", 64'(cfg_pending[1]), 64'd1);
    repeat (20) cycle("ch1 new");

    // Write landing exactly on channel 2's wrap edge.
    en[2] = 1'b1;
    cycle("ch2 start");
    waited = 0;
    while (m_pos[2] != m_p[2] - 1 && waited < 20) begin
      cycle("ch2 wait");
      waited++;
    end
    check("ch2 wrap found", 64'(waited < 20), 64'd1);
    write_cfg(2'd2, 32'd4, 32'd1, "ch2 wr@wrap");
    check("ch2 no pending", 64'(cfg_pending[2]), 64'd0);
    check("ch2 tick on wrap", 64'(tick[2]), 64'd1);
    repeat (10) cycle("ch2 new");

    // Sync aligns all running channels.
    repeat (3) cycle("presync");
    sync = 1'b1;
    cycle("sync");
    check("sync ticks", 64'(tick), 64'(3'b111));
    sync = 1'b0;
    repeat (12) cycle("postsync");

    // Clamp cases.
    write_cfg(2'd0, 32'd1, 32'd1, "clamp p1");
    write_cfg(2'd1, 32'd5, 32'd0, "clamp h0");
    write_cfg(2'd2, 32'd5, 32'd9, "clamp h9");
    repeat (20) cycle("clamp run");

    // Randomised traffic, including disables and out-of-range writes.
    for (int j = 0; j < 3000; j++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 19) == 0) en[c] = ~en[c];
      sync       = ($urandom_range(0, 39) == 0);
      cfg_we     = ($urandom_range(0, 5) == 0);
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_period = $urandom_range(0, 9);
      cfg_high   = $urandom_range(0, 11);
      cycle("rand");
    end
    sync = 1'b0; cfg_we = 1'b0;

    // Async reset mid high phase with a config pending.
    en = '1;
    write_cfg(2'd0, 32'd3, 32'd3, "pre-rst base");
    repeat (3) cycle("pre-rst run");
    waited = 0;
    while (!(m_clk[0] && m_pos[0] != m_p[0] - 1) && waited < 20) begin
      cycle("pre-rst wait");
      waited++;
    end
    write_cfg(2'd0, 32'd9, 32'd4, "pre-rst wr");
    check("pre-rst pending", 64'(cfg_pending[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async rst");
    en = '0;
    @(posedge clk);
    #1;
    check_all("in rst");
    rst_n = 1'b1;
    en[0] = 1'b1;
    for (int j = 0; j < 13; j++) begin
      cycle("post-rst");
      check("post-rst tick0", 64'(tick[0]), 64'((j % 6) == 0));
    end
    write_cfg(2'd3, 32'd2, 32'd1, "bad ch");
    check("bad ch no pending", 64'(cfg_pending), 64'd0);
    repeat (13) cycle("bad ch run");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
